// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: command front-end for the LIFO stack block.
// Accepts one stack-machine op per handshake, sequences the LIFO push/pop
// strobes, and returns an error/carry/top-of-stack response per op.
// Optional feature: define STACK_MUL_EN to enable opcode 10 (MUL); when it
// is undefined opcode 10 is treated as illegal and no multiplier is built.
module stack_op_sequencer #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int COUNTW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_imm,
  output logic              resp_valid,
  output logic [1:0]        resp_err,
  output logic              resp_carry,
  output logic [WIDTH-1:0]  resp_top,
  output logic [WIDTH-1:0]  lifo_data,
  output logic              lifo_push,
  output logic              lifo_pop,
  input  logic [WIDTH-1:0]  lifo_q,
  input  logic [COUNTW-1:0] lifo_count
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_DROP = 4'd2;
  localparam logic [3:0] OP_DUP  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_SWAP = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;
  localparam logic [1:0] ERR_ILL   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH, S_POP, S_FETCH_A, S_FETCH_B, S_EXEC, S_PUSH2, S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       err_q, err_d;
  logic             carry_q, carry_d;
  // Low while reset is held so cmd_ready only rises after release.
  logic             live_q;

  logic             is_binary, is_legal, accept;
  logic [WIDTH-1:0] exec_result;
  logic             exec_carry;
  logic [WIDTH:0]   sum_w, diff_w;

  // Classify the incoming opcode for the accept-time checks.
  always_comb begin
    is_binary = 1'b0;
    is_legal  = 1'b0;
    case (cmd_op)
      OP_NOP, OP_PUSH, OP_DROP, OP_DUP: is_legal = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SWAP: begin
        is_legal  = 1'b1;
        is_binary = 1'b1;
      end
`ifdef STACK_MUL_EN
      OP_MUL: begin
        is_legal  = 1'b1;
        is_binary = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign accept = cmd_valid & cmd_ready;
  assign sum_w  = {1'b0, b_q} + {1'b0, a_q};
  assign diff_w = {1'b0, b_q} - {1'b0, a_q};

`ifdef STACK_MUL_EN
  logic [2*WIDTH-1:0] prod_w;
  assign prod_w = {{WIDTH{1'b0}}, b_q} * {{WIDTH{1'b0}}, a_q};
`endif

  // ALU: result pushed in EXEC (b op a); SWAP pushes a first.
  always_comb begin
    exec_result = a_q;
    exec_carry  = 1'b0;
    case (op_q)
      OP_ADD: begin exec_result = sum_w[WIDTH-1:0];  exec_carry = sum_w[WIDTH];  end
      OP_SUB: begin exec_result = diff_w[WIDTH-1:0]; exec_carry = diff_w[WIDTH]; end
      OP_AND: exec_result = b_q & a_q;
      OP_OR:  exec_result = b_q | a_q;
      OP_XOR: exec_result = b_q ^ a_q;
`ifdef STACK_MUL_EN
      OP_MUL: begin
        exec_result = prod_w[WIDTH-1:0];
        exec_carry  = |prod_w[2*WIDTH-1:WIDTH];
      end
`endif
      default: ;
    endcase
  end

  // Next-state and output decode; outputs are idle unless a state drives them.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    imm_d      = imm_q;
    a_d        = a_q;
    b_d        = b_q;
    err_d      = err_q;
    carry_d    = carry_q;
    cmd_ready  = live_q & (state_q == S_IDLE);
    resp_valid = 1'b0;
    resp_err   = 2'd0;
    resp_carry = 1'b0;
    resp_top   = '0;
    lifo_data  = '0;
    lifo_push  = 1'b0;
    lifo_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = cmd_op;
          imm_d   = cmd_imm;
          carry_d = 1'b0;
          err_d   = ERR_OK;
          if (!is_legal) begin
            err_d   = ERR_ILL;
            state_d = S_RESP;
          end else if ((((cmd_op == OP_DROP) || (cmd_op == OP_DUP)) && (lifo_count == '0)) ||
                       (is_binary && (lifo_count < COUNTW'(2)))) begin
            err_d   = ERR_UNDER;
            state_d = S_RESP;
          end else if (((cmd_op == OP_PUSH) || (cmd_op == OP_DUP)) &&
                       (lifo_count == COUNTW'(DEPTH))) begin
            err_d   = ERR_OVER;
            state_d = S_RESP;
          end else if ((cmd_op == OP_PUSH) || (cmd_op == OP_DUP)) begin
            state_d = S_PUSH;
          end else if (cmd_op == OP_DROP) begin
            state_d = S_POP;
          end else if (is_binary) begin
            state_d = S_FETCH_A;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_PUSH: begin
        lifo_push = 1'b1;
        lifo_data = (op_q == OP_DUP) ? lifo_q : imm_q;
        state_d   = S_RESP;
      end
      S_POP: begin
        lifo_pop = 1'b1;
        state_d  = S_RESP;
      end
      S_FETCH_A: begin
        a_d      = lifo_q;
        lifo_pop = 1'b1;
        state_d  = S_FETCH_B;
      end
      S_FETCH_B: begin
        b_d      = lifo_q;
        lifo_pop = 1'b1;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        lifo_push = 1'b1;
        lifo_data = exec_result;
        carry_d   = exec_carry;
        state_d   = (op_q == OP_SWAP) ? S_PUSH2 : S_RESP;
      end
      S_PUSH2: begin
        lifo_push = 1'b1;
        lifo_data = b_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_carry = carry_q;
        resp_top   = (lifo_count != '0) ? lifo_q : '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and operand registers; reset abandons any op in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= ERR_OK;
      carry_q <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      carry_q <= carry_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Testbench for stack_op_sequencer with a behavioural LIFO attached.
// Expected responses come from a queue-based stack model and go through a
// scoreboard queue; set STACK_MUL_EN to match the RTL build.
module tb_stack_op_sequencer;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int CW = 5;
`ifdef STACK_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = 4'd0;
  logic [W-1:0]  cmd_imm = '0;
  logic          resp_valid;
  logic [1:0]    resp_err;
  logic          resp_carry;
  logic [W-1:0]  resp_top;
  logic [W-1:0]  lifo_data;
  logic          lifo_push;
  logic          lifo_pop;
  logic [W-1:0]  lifo_q;
  logic [CW-1:0] lifo_count;

  always #5 clock = ~clock;

  stack_op_sequencer #(.WIDTH(W), .DEPTH(D), .COUNTW(CW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_carry(resp_carry), .resp_top(resp_top),
    .lifo_data(lifo_data), .lifo_push(lifo_push), .lifo_pop(lifo_pop),
    .lifo_q(lifo_q), .lifo_count(lifo_count)
  );

  // Behavioural LIFO sharing the sequencer reset
  logic [W-1:0]  mem [D];
  logic [CW-1:0] cnt;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (lifo_push && cnt < CW'(D)) begin
      mem[cnt[3:0]] <= lifo_data;
      cnt <= cnt + 1'b1;
    end else if (lifo_pop && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign lifo_count = cnt;
  assign lifo_q = (cnt != '0) ? mem[4'(cnt - 5'd1)] : '0;

  typedef struct {
    logic [1:0]   err;
    logic         carry;
    logic [W-1:0] top;
    int           lat;
    int           npush;
    int           npop;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] ms[$];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] obs_top;
  logic [1:0]   obs_err;
  logic         obs_carry;

  // Reference stack model: updates ms and returns the expected response
  function automatic exp_t model_op(input logic [3:0] op, input logic [W-1:0] imm);
    exp_t e;
    logic [W-1:0] a, b, r;
    logic [W:0] t;
    logic [2*W-1:0] p;
    bit binary, legal;
    e.err = 2'd0; e.carry = 1'b0; e.lat = 1; e.npush = 0; e.npop = 0;
    binary = (op >= 4'd4 && op <= 4'd9) || (MUL_EN && op == 4'd10);
    legal  = (op <= 4'd9) || (MUL_EN && op == 4'd10);
    if (!legal) e.err = 2'd3;
    else if (((op == 4'd2 || op == 4'd3) && ms.size() < 1) || (binary && ms.size() < 2)) e.err = 2'd1;
    else if ((op == 4'd1 || op == 4'd3) && ms.size() == D) e.err = 2'd2;
    else begin
      case (op)
        4'd0: e.lat = 1;
        4'd1: begin ms.push_back(imm); e.lat = 2; e.npush = 1; end
        4'd3: begin ms.push_back(ms[$]); e.lat = 2; e.npush = 1; end
        4'd2: begin void'(ms.pop_back()); e.lat = 2; e.npop = 1; end
        default: begin
          a = ms.pop_back();
          b = ms.pop_back();
          e.npop = 2; e.lat = 4; e.npush = 1;
          r = '0;
          case (op)
            4'd4: begin t = {1'b0, b} + {1'b0, a}; r = t[W-1:0]; e.carry = t[W]; end
            4'd5: begin t = {1'b0, b} - {1'b0, a}; r = t[W-1:0]; e.carry = t[W]; end
            4'd6: r = b & a;
            4'd7: r = b | a;
            4'd8: r = b ^ a;
            4'd10: begin p = 32'(b) * 32'(a); r = p[W-1:0]; e.carry = |p[2*W-1:W]; end
            default: ;
          endcase
          if (op == 4'd9) begin
            ms.push_back(a); ms.push_back(b);
            e.lat = 5; e.npush = 2;
          end else ms.push_back(r);
        end
      endcase
    end
    e.top = (ms.size() > 0) ? ms[$] : '0;
    return e;
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    cmd_valid = 1'b0;
    ms.delete();
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [W-1:0] imm);
    exp_t e;
    int lat, np, npo;
    bit both, got;
    sb.push_back(model_op(op, imm));
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready op=%0d got %b want 1", op, cmd_ready); end
    @(posedge clock); #1;
    cmd_valid = 1'b0; cmd_op = 4'd0; cmd_imm = '0;
    lat = 1; np = 0; npo = 0; both = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (resp_valid === 1'b1) begin got = 1; break; end
      if (lifo_push) np++;
      if (lifo_pop) npo++;
      if (lifo_push && lifo_pop) both = 1;
      @(posedge clock);
      lat++;
    end
    e = sb.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL resp_timeout op=%0d got no resp_valid want resp within 20 cycles", op);
    end else begin
      checks++; if (resp_err !== e.err) begin errors++; $display("FAIL resp_err op=%0d got %0d want %0d", op, resp_err, e.err); end
      checks++; if (resp_carry !== e.carry) begin errors++; $display("FAIL resp_carry op=%0d got %b want %b", op, resp_carry, e.carry); end
      checks++; if (resp_top !== e.top) begin errors++; $display("FAIL resp_top op=%0d got %h want %h", op, resp_top, e.top); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL latency op=%0d got %0d want %0d", op, lat, e.lat); end
      checks++; if (np != e.npush || npo != e.npop) begin errors++; $display("FAIL strobes op=%0d got push=%0d pop=%0d want push=%0d pop=%0d", op, np, npo, e.npush, e.npop); end
      checks++; if (both || lifo_push || lifo_pop) begin errors++; $display("FAIL strobe_overlap op=%0d got overlap=%b resp_push=%b resp_pop=%b want 0", op, both, lifo_push, lifo_pop); end
      checks++; if (int'(lifo_count) != ms.size()) begin errors++; $display("FAIL lifo_count op=%0d got %0d want %0d", op, lifo_count, ms.size()); end
    end
    obs_top = resp_top; obs_err = resp_err; obs_carry = resp_carry;
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL resp_pulse op=%0d got valid=%b ready=%b want valid=0 ready=1", op, resp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({resp_valid, resp_err, resp_carry, resp_top, lifo_data, lifo_push, lifo_pop, cmd_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b err=%0d carry=%b top=%h data=%h push=%b pop=%b ready=%b want all 0",
               resp_valid, resp_err, resp_carry, resp_top, lifo_data, lifo_push, lifo_pop, cmd_ready);
    end
    apply_reset();
    checks++;
    if (cmd_ready !== 1'b1 || lifo_count !== '0) begin
      errors++; $display("FAIL reset_release got ready=%b count=%0d want ready=1 count=0", cmd_ready, lifo_count);
    end
  endtask

  task automatic test_arith();
    apply_reset();
    do_cmd(4'd1, 16'd5); do_cmd(4'd1, 16'd3); do_cmd(4'd4, '0);
    checks++;
    if (obs_top !== 16'd8 || obs_carry !== 1'b0 || obs_err !== 2'd0 || lifo_count !== 5'd1) begin
      errors++; $display("FAIL add_5_3 got top=%h carry=%b err=%0d count=%0d want 0008 0 0 1", obs_top, obs_carry, obs_err, lifo_count);
    end
    do_cmd(4'd1, 16'd3); do_cmd(4'd1, 16'd5); do_cmd(4'd5, '0);
    checks++;
    if (obs_top !== 16'hFFFE || obs_carry !== 1'b1) begin
      errors++; $display("FAIL sub_3_5 got top=%h carry=%b want fffe 1", obs_top, obs_carry);
    end
    do_cmd(4'd1, 16'hFFFF); do_cmd(4'd1, 16'd1); do_cmd(4'd4, '0);
    checks++;
    if (obs_top !== 16'h0000 || obs_carry !== 1'b1) begin
      errors++; $display("FAIL add_wrap got top=%h carry=%b want 0000 1", obs_top, obs_carry);
    end
    do_cmd(4'd1, 16'hF0F0); do_cmd(4'd1, 16'h3C3C); do_cmd(4'd6, '0);
    do_cmd(4'd1, 16'h0101); do_cmd(4'd7, '0);
    do_cmd(4'd1, 16'hFFFF); do_cmd(4'd8, '0);
    do_cmd(4'd3, '0); do_cmd(4'd0, '0);
  endtask

  task automatic test_errors();
    apply_reset();
    do_cmd(4'd2, '0);
    checks++;
    if (obs_err !== 2'd1) begin errors++; $display("FAIL drop_empty got err=%0d want 1", obs_err); end
    do_cmd(4'd3, '0);
    do_cmd(4'd1, 16'd4); do_cmd(4'd4, '0);
    do_cmd(4'd15, '0);
    checks++;
    if (obs_err !== 2'd3) begin errors++; $display("FAIL op15 got err=%0d want 3", obs_err); end
    for (int i = 1; i < D; i++) do_cmd(4'd1, 16'($urandom));
    do_cmd(4'd1, 16'h1234);
    checks++;
    if (obs_err !== 2'd2 || lifo_count !== 5'd16) begin
      errors++; $display("FAIL push_full got err=%0d count=%0d want 2 16", obs_err, lifo_count);
    end
    do_cmd(4'd3, '0);
  endtask

  task automatic test_swap();
    apply_reset();
    do_cmd(4'd1, 16'd1); do_cmd(4'd1, 16'd2); do_cmd(4'd9, '0);
    checks++;
    if (obs_top !== 16'd1 || lifo_count !== 5'd2) begin
      errors++; $display("FAIL swap got top=%h count=%0d want 0001 2", obs_top, lifo_count);
    end
    do_cmd(4'd2, '0);
    checks++;
    if (obs_top !== 16'd2) begin errors++; $display("FAIL swap_drop got top=%h want 0002", obs_top); end
  endtask

  task automatic test_mul();
    apply_reset();
    do_cmd(4'd1, 16'd7); do_cmd(4'd1, 16'd6); do_cmd(4'd10, '0);
    checks++;
    if (MUL_EN ? (obs_top !== 16'd42 || obs_err !== 2'd0) : (obs_err !== 2'd3 || lifo_count !== 5'd2)) begin
      errors++; $display("FAIL op10 got top=%h err=%0d count=%0d want mul_en=%0b", obs_top, obs_err, lifo_count, MUL_EN);
    end
    do_cmd(4'd1, 16'h1000); do_cmd(4'd1, 16'h0100); do_cmd(4'd10, '0);
  endtask

  task automatic test_reset_midop();
    apply_reset();
    do_cmd(4'd1, 16'd5); do_cmd(4'd1, 16'd3);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 4'd4;
    @(posedge clock); #1;
    cmd_valid = 1'b0; cmd_op = 4'd0;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({resp_valid, resp_err, resp_carry, resp_top, lifo_data, lifo_push, lifo_pop, cmd_ready} !== '0 || lifo_count !== '0) begin
      errors++;
      $display("FAIL midop_reset got valid=%b push=%b pop=%b data=%h ready=%b count=%0d want all 0",
               resp_valid, lifo_push, lifo_pop, lifo_data, cmd_ready, lifo_count);
    end
    ms.delete();
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1 || lifo_push !== 1'b0 || lifo_pop !== 1'b0) begin
      errors++; $display("FAIL midop_idle got ready=%b push=%b pop=%b want 1 0 0", cmd_ready, lifo_push, lifo_pop);
    end
    do_cmd(4'd1, 16'd9);
    checks++;
    if (obs_top !== 16'd9 || lifo_count !== 5'd1) begin
      errors++; $display("FAIL push_after_reset got top=%h count=%0d want 0009 1", obs_top, lifo_count);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = (i < 6) ? 4'd1 : 4'($urandom_range(0, 11));
      do_cmd(op, 16'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_errors();
    test_swap();
    test_mul();
    test_reset_midop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
